// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a power-of-two framebuffer window.
// Stage 1 decodes the raster position and issues the RAM address; stage 2 muxes colour and syncs.
module vga_timing_gen #(
    parameter int                 CLK_DIV      = 2,
    parameter int                 H_VISIBLE    = 640,
    parameter int                 H_FRONT      = 16,
    parameter int                 H_SYNC       = 96,
    parameter int                 H_BACK       = 48,
    parameter int                 V_VISIBLE    = 480,
    parameter int                 V_FRONT      = 10,
    parameter int                 V_SYNC       = 2,
    parameter int                 V_BACK       = 33,
    parameter bit                 HSYNC_POL    = 1'b0,
    parameter bit                 VSYNC_POL    = 1'b0,
    parameter int                 WIN_X        = 192,
    parameter int                 WIN_Y        = 112,
    parameter int                 WIN_W_LOG2   = 8,
    parameter int                 WIN_H_LOG2   = 8,
    parameter int                 COLOR_W      = 3,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = '0
) (
    input  logic                             Clock,
    input  logic                             Reset_n,
    output logic [WIN_W_LOG2+WIN_H_LOG2-1:0] oReadAddress,
    input  logic [COLOR_W-1:0]               iColor,
    output logic                             oVGA_Red,
    output logic                             oVGA_Green,
    output logic                             oVGA_Blue,
    output logic                             oHSync,
    output logic                             oVSync,
    output logic                             oPixelTick,
    output logic                             oActive,
    output logic                             oFrameStart
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_W          = $clog2(H_TOTAL);
    localparam int V_W          = $clog2(V_TOTAL);
    localparam int DIV_W        = $clog2(CLK_DIV);
    localparam int ADDR_W       = WIN_W_LOG2 + WIN_H_LOG2;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int WIN_X_END    = WIN_X + (2 ** WIN_W_LOG2);
    localparam int WIN_Y_END    = WIN_Y + (2 ** WIN_H_LOG2);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic inwin;
        logic origin;
    } stage1_t;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [H_W-1:0]     hcount_q, hcount_d;
    logic [V_W-1:0]     vcount_q, vcount_d;
    stage1_t            s1_q, s1_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic               frame_start_q, frame_start_d;

    logic               tick;
    logic               h_wrap;
    logic               v_wrap;
    logic [31:0]        h_pos;
    logic [31:0]        v_pos;

    assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_wrap = (hcount_q == H_W'(H_TOTAL - 1));
    assign v_wrap = (vcount_q == V_W'(V_TOTAL - 1));
    assign h_pos  = 32'(hcount_q);
    assign v_pos  = 32'(vcount_q);

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            hcount_d = h_wrap ? '0 : hcount_q + H_W'(1);
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + V_W'(1);
            end
        end
    end

    // Offsets are only formed inside the window, so the truncating subtraction never underflows.
    always_comb begin
        s1_d   = s1_q;
        addr_d = addr_q;
        if (tick) begin
            s1_d.active = (h_pos < 32'(H_VISIBLE)) && (v_pos < 32'(V_VISIBLE));
            s1_d.hsync  = (h_pos >= 32'(H_SYNC_START)) && (h_pos < 32'(H_SYNC_END));
            s1_d.vsync  = (v_pos >= 32'(V_SYNC_START)) && (v_pos < 32'(V_SYNC_END));
            s1_d.inwin  = s1_d.active
                        && (h_pos >= 32'(WIN_X)) && (h_pos < 32'(WIN_X_END))
                        && (v_pos >= 32'(WIN_Y)) && (v_pos < 32'(WIN_Y_END));
            s1_d.origin = (hcount_q == '0) && (vcount_q == '0);
            addr_d      = s1_d.inwin
                        ? {WIN_H_LOG2'(v_pos - 32'(WIN_Y)), WIN_W_LOG2'(h_pos - 32'(WIN_X))}
                        : '0;
        end
    end

    always_comb begin
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        frame_start_d = tick & s1_q.origin;
        if (tick) begin
            if (s1_q.inwin) begin
                rgb_d = iColor;
            end else if (s1_q.active) begin
                rgb_d = BORDER_COLOR;
            end else begin
                rgb_d = '0;
            end
            hsync_d  = s1_q.hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync_d  = s1_q.vsync ? VSYNC_POL : ~VSYNC_POL;
            active_d = s1_q.active;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            s1_q          <= '0;
            addr_q        <= '0;
            rgb_q         <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            s1_q          <= s1_d;
            addr_q        <= addr_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign oReadAddress = addr_q;
    assign oVGA_Red     = rgb_q[COLOR_W-1];
    assign oVGA_Green   = rgb_q[COLOR_W-2];
    assign oVGA_Blue    = rgb_q[COLOR_W-3];
    assign oHSync       = hsync_q;
    assign oVSync       = vsync_q;
    assign oPixelTick   = tick;
    assign oActive      = active_q;
    assign oFrameStart  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations compared cycle by cycle against an arithmetic raster model.
// RAM contents are random; expected outputs are derived from the tick index since reset release.
module tb_vga_timing_gen;

    typedef struct packed {
        int div, hv, hf, hs, hb, vv, vf, vs, vb, wx, wy, wwl, whl, hp, vp, border;
    } cfg_t;

    typedef struct packed {
        int sel, h, v, addr;
    } corner_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d;
    int   n_pass  = 0;
    int   n_total = 0;
    int   clk_cnt [4];
    corner_t corners [15];

    logic [6:0]  a_addr;  logic [2:0] a_color;
    logic [6:0]  b_addr;  logic [2:0] b_color;
    logic [15:0] c_addr;  logic [2:0] c_color;
    logic [12:0] d_addr;  logic [2:0] d_color;
    logic a_r, a_g, a_b, a_hs, a_vs, a_tick, a_act, a_fs;
    logic b_r, b_g, b_b, b_hs, b_vs, b_tick, b_act, b_fs;
    logic c_r, c_g, c_b, c_hs, c_vs, c_tick, c_act, c_fs;
    logic d_r, d_g, d_b, d_hs, d_vs, d_tick, d_act, d_fs;

    logic [2:0] ram_a [128];
    logic [2:0] ram_b [128];
    logic [2:0] ram_c [65536];
    logic [2:0] ram_d [8192];

    always @(posedge clk) begin
        a_color <= ram_a[a_addr];
        b_color <= ram_b[b_addr];
        c_color <= ram_c[c_addr];
        d_color <= ram_d[d_addr];
    end

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .WIN_X(8), .WIN_Y(4),
        .WIN_W_LOG2(4), .WIN_H_LOG2(3), .COLOR_W(3), .BORDER_COLOR(3'b101)
    ) dut_a (
        .Clock(clk), .Reset_n(rst_a), .oReadAddress(a_addr), .iColor(a_color),
        .oVGA_Red(a_r), .oVGA_Green(a_g), .oVGA_Blue(a_b), .oHSync(a_hs), .oVSync(a_vs),
        .oPixelTick(a_tick), .oActive(a_act), .oFrameStart(a_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VISIBLE(30), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(3), .V_BACK(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .WIN_X(20), .WIN_Y(6),
        .WIN_W_LOG2(4), .WIN_H_LOG2(3), .COLOR_W(3), .BORDER_COLOR(3'b010)
    ) dut_b (
        .Clock(clk), .Reset_n(rst_b), .oReadAddress(b_addr), .iColor(b_color),
        .oVGA_Red(b_r), .oVGA_Green(b_g), .oVGA_Blue(b_b), .oHSync(b_hs), .oVSync(b_vs),
        .oPixelTick(b_tick), .oActive(b_act), .oFrameStart(b_fs)
    );

    vga_timing_gen dut_c (
        .Clock(clk), .Reset_n(rst_c), .oReadAddress(c_addr), .iColor(c_color),
        .oVGA_Red(c_r), .oVGA_Green(c_g), .oVGA_Blue(c_b), .oHSync(c_hs), .oVSync(c_vs),
        .oPixelTick(c_tick), .oActive(c_act), .oFrameStart(c_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .WIN_X(10), .WIN_Y(10),
        .WIN_W_LOG2(7), .WIN_H_LOG2(6), .COLOR_W(3), .BORDER_COLOR(3'b011)
    ) dut_d (
        .Clock(clk), .Reset_n(rst_d), .oReadAddress(d_addr), .iColor(d_color),
        .oVGA_Red(d_r), .oVGA_Green(d_g), .oVGA_Blue(d_b), .oHSync(d_hs), .oVSync(d_vs),
        .oPixelTick(d_tick), .oActive(d_act), .oFrameStart(d_fs)
    );

    function automatic cfg_t get_cfg(input int sel);
        cfg_t g;
        case (sel)
            0:       g = '{2, 40, 4, 6, 5, 20, 2, 2, 3, 8, 4, 4, 3, 0, 0, 5};
            1:       g = '{3, 30, 3, 5, 4, 12, 1, 3, 2, 20, 6, 4, 3, 1, 1, 2};
            2:       g = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 192, 112, 8, 8, 0, 0, 0};
            default: g = '{4, 800, 40, 128, 88, 600, 1, 4, 23, 10, 10, 7, 6, 0, 0, 3};
        endcase
        return g;
    endfunction

    function automatic logic [2:0] ram_rd(input int sel, input int addr);
        case (sel)
            0:       return ram_a[addr];
            1:       return ram_b[addr];
            2:       return ram_c[addr];
            default: return ram_d[addr];
        endcase
    endfunction

    // Raster position of the p-th pixel period after reset release.
    function automatic void pos(input cfg_t g, input int p, output int h, output int v);
        int ht, vt;
        ht = g.hv + g.hf + g.hs + g.hb;
        vt = g.vv + g.vf + g.vs + g.vb;
        h  = p % ht;
        v  = (p / ht) % vt;
    endfunction

    function automatic bit in_window(input cfg_t g, input int h, input int v);
        return (h < g.hv) && (v < g.vv) && (h >= g.wx) && (h < g.wx + (1 << g.wwl))
            && (v >= g.wy) && (v < g.wy + (1 << g.whl));
    endfunction

    function automatic int win_addr(input cfg_t g, input int p);
        int h, v;
        pos(g, p, h, v);
        return in_window(g, h, v) ? ((v - g.wy) << g.wwl) + (h - g.wx) : 0;
    endfunction

    // Expected {addr, rgb, hsync, vsync, active, frame_start, tick} after c clocks since release.
    function automatic logic [39:0] model(input int sel, input int c);
        cfg_t g;
        int k, h, v, ht, vt, addr;
        logic [2:0] rgb;
        logic hs, vs, act, fs, tk;
        g    = get_cfg(sel);
        ht   = g.hv + g.hf + g.hs + g.hb;
        vt   = g.vv + g.vf + g.vs + g.vb;
        k    = c / g.div;
        tk   = (c % g.div) == (g.div - 1);
        addr = 0;
        rgb  = 3'b000;
        hs   = (g.hp == 0);
        vs   = (g.vp == 0);
        act  = 1'b0;
        fs   = 1'b0;
        if (k >= 1) addr = win_addr(g, k - 1);
        if (k >= 2) begin
            pos(g, k - 2, h, v);
            act = (h < g.hv) && (v < g.vv);
            hs  = ((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs)) ? (g.hp != 0) : (g.hp == 0);
            vs  = ((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs)) ? (g.vp != 0) : (g.vp == 0);
            if (in_window(g, h, v)) rgb = ram_rd(sel, win_addr(g, k - 2));
            else if (act)           rgb = 3'(g.border);
            fs  = (((k - 2) % (ht * vt)) == 0) && ((c % g.div) == 0);
        end
        return {32'(addr), rgb, hs, vs, act, fs, tk};
    endfunction

    function automatic logic [39:0] sample(input int sel);
        case (sel)
            0:       return {32'(a_addr), a_r, a_g, a_b, a_hs, a_vs, a_act, a_fs, a_tick};
            1:       return {32'(b_addr), b_r, b_g, b_b, b_hs, b_vs, b_act, b_fs, b_tick};
            2:       return {32'(c_addr), c_r, c_g, c_b, c_hs, c_vs, c_act, c_fs, c_tick};
            default: return {32'(d_addr), d_r, d_g, d_b, d_hs, d_vs, d_act, d_fs, d_tick};
        endcase
    endfunction

    function automatic string fmt(input logic [39:0] x);
        return $sformatf("addr=%h rgb=%b hs=%b vs=%b act=%b fs=%b tick=%b",
                         x[39:8], x[7:5], x[4], x[3], x[2], x[1], x[0]);
    endfunction

    function automatic logic [39:0] reset_vec(input int sel);
        cfg_t g;
        g = get_cfg(sel);
        return {32'd0, 3'b000, (g.hp == 0), (g.vp == 0), 1'b0, 1'b0, 1'b0};
    endfunction

    task automatic set_rst(input int sel, input logic val);
        case (sel)
            0:       rst_a = val;
            1:       rst_b = val;
            2:       rst_c = val;
            default: rst_d = val;
        endcase
    endtask

    task automatic release_dut(input int sel);
        @(negedge clk);
        set_rst(sel, 1'b1);
        clk_cnt[sel] = 0;
    endtask

    task automatic run_compare(input int sel, input int nclk, input string name);
        cfg_t g;
        logic [39:0] obs, exp_v;
        int ht;
        g  = get_cfg(sel);
        ht = g.hv + g.hf + g.hs + g.hb;
        for (int i = 0; i < nclk; i++) begin
            @(posedge clk);
            clk_cnt[sel]++;
            @(negedge clk);
            obs   = sample(sel);
            exp_v = model(sel, clk_cnt[sel]);
            n_total++;
            if (obs !== exp_v)
                $display("FAIL %s dut=%0d clk=%0d got %s expected %s",
                         name, sel, clk_cnt[sel], fmt(obs), fmt(exp_v));
            else
                n_pass++;
            for (int j = 0; j < 15; j++) begin
                if (corners[j].sel == sel
                    && clk_cnt[sel] == (corners[j].v * ht + corners[j].h + 1) * g.div) begin
                    n_total++;
                    if (obs[39:8] !== 32'(corners[j].addr))
                        $display("FAIL corner_addr dut=%0d pixel=(%0d,%0d) got %h expected %h",
                                 sel, corners[j].h, corners[j].v, obs[39:8], corners[j].addr);
                    else
                        n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [39:0] obs;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        foreach (ram_a[i]) ram_a[i] = 3'($urandom);
        foreach (ram_b[i]) ram_b[i] = 3'($urandom);
        foreach (ram_c[i]) ram_c[i] = 3'($urandom);
        foreach (ram_d[i]) ram_d[i] = 3'($urandom);
        corners = '{
            '{0, 8, 4, 0}, '{0, 23, 4, 15}, '{0, 8, 5, 16}, '{0, 23, 11, 127},
            '{0, 7, 4, 0}, '{0, 24, 6, 0},
            '{1, 29, 6, 9}, '{1, 20, 7, 16}, '{1, 29, 11, 89}, '{1, 30, 6, 0},
            '{3, 10, 10, 0}, '{3, 137, 10, 127}, '{3, 10, 11, 128}, '{3, 9, 10, 0},
            '{3, 138, 10, 0}
        };
        repeat (4) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            obs = sample(s);
            n_total++;
            if (obs !== reset_vec(s))
                $display("FAIL reset_state dut=%0d got %s expected %s", s, fmt(obs), fmt(reset_vec(s)));
            else
                n_pass++;
        end
    endtask

    task automatic test_window_colour();
        release_dut(0);
        run_compare(0, 3300, "window_colour");
    endtask

    task automatic test_async_reset();
        logic [39:0] obs;
        run_compare(0, int'($urandom_range(400, 1800)), "pre_reset");
        #2;
        rst_a = 1'b0;
        #1;
        obs = sample(0);
        n_total++;
        if (obs !== reset_vec(0))
            $display("FAIL async_reset got %s expected %s", fmt(obs), fmt(reset_vec(0)));
        else
            n_pass++;
        repeat (3) @(negedge clk);
        release_dut(0);
        run_compare(0, 400, "restart");
    endtask

    task automatic test_polarity_clip();
        release_dut(1);
        run_compare(1, 2400, "polarity_clip");
    endtask

    task automatic test_default_line();
        release_dut(2);
        run_compare(2, 3300, "default_timing");
    endtask

    task automatic test_sweep();
        release_dut(3);
        run_compare(3, 47300, "sweep_800x600");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_window_colour();
        test_async_reset();
        test_polarity_clip();
        test_default_line();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
